// File: rtl/fetch_ctrl_if.sv
// ---------------------------------------------------------------------------
// fetch_ctrl_if
//   Bundles every non-clock, non-reset signal of the instruction-fetch
//   sequencer. This covers the run control, the instruction-ROM port, the
//   branch redirect request and the {pc, instr} valid/ready channel
//   towards decode.
//
//   Signals (direction as seen by the fetch sequencer, modport master):
//     start        in   1-cycle pulse, IDLE -> RUN
//     imem_addr    out  ROM word address (pc[ADDR_W+1:2])
//     imem_q       in   ROM data, combinational from imem_addr
//     redir_valid  in   branch redirect request
//     redir_pc     in   redirect target; bits [1:0] ignored
//     out_valid    out  FIFO head is valid
//     out_ready    in   decode accepts the head this cycle
//     out_instr    out  head instruction
//     out_pc       out  head PC
//     halted       out  sequencer is in HALT
//     busy         out  sequencer is in RUN
//   The slave modport is the mirror image, used by the ROM/decode side.
// ---------------------------------------------------------------------------
interface fetch_ctrl_if #(
    parameter int N      = 64,
    parameter int ISIZE  = 32,
    parameter int ADDR_W = 6
);
    logic              start;
    logic [ADDR_W-1:0] imem_addr;
    logic [ISIZE-1:0]  imem_q;
    logic              redir_valid;
    logic [N-1:0]      redir_pc;
    logic              out_valid;
    logic              out_ready;
    logic [ISIZE-1:0]  out_instr;
    logic [N-1:0]      out_pc;
    logic              halted;
    logic              busy;

    modport master (
        input  start, imem_q, redir_valid, redir_pc, out_ready,
        output imem_addr, out_valid, out_instr, out_pc, halted, busy
    );

    modport slave (
        output start, imem_q, redir_valid, redir_pc, out_ready,
        input  imem_addr, out_valid, out_instr, out_pc, halted, busy
    );
endinterface

// File: rtl/fetch_ctrl.sv
// ---------------------------------------------------------------------------
// fetch_ctrl
//   Instruction-fetch sequencer for the single-cycle LEGv8 core. It owns the
//   program counter and drives the word address of a combinational
//   instruction ROM. It also buffers fetched {pc, instr} pairs in a small
//   FIFO towards decode. Branch redirects flush the FIFO and reload the PC.
//   Fetching stops at the end-of-program marker, which is an all-zero word.
//
//   Ports:
//     clk    rising-edge clock
//     reset  asynchronous, active-high reset
//     bus    fetch_ctrl_if.master (ROM port, redirect, decode channel,
//            start/halted/busy)
//
//   Parameters:
//     N         PC width in bits
//     ISIZE     instruction width (equal to the ROM word width)
//     ADDR_W    ROM word-address width
//     DEPTH     fetch FIFO entries (>= 1)
//     RESET_PC  PC value loaded on reset
// ---------------------------------------------------------------------------
module fetch_ctrl #(
    parameter int           N        = 64,
    parameter int           ISIZE    = 32,
    parameter int           ADDR_W   = 6,
    parameter int           DEPTH    = 2,
    parameter logic [N-1:0] RESET_PC = '0
) (
    input  logic          clk,
    input  logic          reset,
    fetch_ctrl_if.master  bus
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_HALT = 2'd2
    } state_e;

    typedef struct packed {
        logic [N-1:0]     pc;
        logic [ISIZE-1:0] instr;
    } entry_t;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_e            state_q,  state_d;
    logic [N-1:0]      pc_q,     pc_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]  count_q,  count_d;
    logic              halted_q, halted_d;
    logic              busy_q,   busy_d;

    entry_t            fifo_mem [DEPTH];

    logic              out_valid;
    logic              push;
    logic              pop;
    logic              push_ok;

    // The two low bits of the redirect target are forced to zero and
    // never read.
    logic [1:0]        unused_redir_lsb;
    assign unused_redir_lsb = bus.redir_pc[1:0];

    // Circular pointer advance that also works for non-power-of-two depths.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    assign out_valid = (count_q != '0);

    always_comb begin
        // NOTE: every signal gets a default first, so no path leaves one unassigned (no latches).
        state_d  = state_q;
        pc_d     = pc_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        push_ok  = 1'b0;
        push     = 1'b0;
        pop      = 1'b0;

        if (bus.redir_valid) begin
            // A redirect beats everything. It flushes the FIFO, reloads the
            // word-aligned target and blocks this cycle's push and pop.
            pc_d     = {bus.redir_pc[N-1:2], 2'b00};
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
            unique case (state_q)
                S_IDLE:  if (bus.start) state_d = S_RUN;
                S_HALT:  state_d = S_RUN;
                default: state_d = state_q;
            endcase
        end else begin
            pop = out_valid & bus.out_ready;

            if (state_q == S_IDLE && bus.start) begin
                state_d = S_RUN;
            end

            // A slot is free if the FIFO is not full, or if the head
            // leaves in the same cycle.
            push_ok = (state_q == S_RUN) && ((count_q < CNT_W'(DEPTH)) || pop);

            if (push_ok) begin
                if (bus.imem_q == '0) begin
                    // End-of-program marker. It is not queued, and the PC
                    // stays on it.
                    state_d = S_HALT;
                end else begin
                    push = 1'b1;
                    pc_d = pc_q + N'(4);
                end
            end

            if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
            if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);

            unique case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Status outputs are registered. They follow the state that the next
    // edge will enter.
    always_comb begin
        busy_d   = (state_d == S_RUN);
        halted_d = (state_d == S_HALT);
    end

    // ------------------------------------------------------------------
    // Sequencer and FIFO control registers
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            pc_q     <= RESET_PC;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            halted_q <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            halted_q <= halted_d;
            busy_q   <= busy_d;
        end
    end

    // ------------------------------------------------------------------
    // FIFO storage
    // ------------------------------------------------------------------
    // NOTE: the storage array is not reset. An empty count makes its contents irrelevant.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= '{pc: pc_q, instr: bus.imem_q};
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.imem_addr = pc_q[ADDR_W+1:2];
    assign bus.out_valid = out_valid;

    // The head is forced to zero while the FIFO is empty. This keeps the
    // reset and flush values clean without resetting the storage.
    assign bus.out_instr = out_valid ? fifo_mem[rd_ptr_q].instr : '0;
    assign bus.out_pc    = out_valid ? fifo_mem[rd_ptr_q].pc    : '0;
    assign bus.halted    = halted_q;
    assign bus.busy      = busy_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// ---------------------------------------------------------------------------
// tb_fetch_ctrl
//   Directed bench for fetch_ctrl (DEPTH=2). It models the combinational
//   instruction ROM and walks through the scenarios in sequence: streaming
//   delivery, stalls, redirects, halt/drain, mid-run reset, IDLE redirect
//   and full-FIFO back-to-back operation.
// ---------------------------------------------------------------------------
module tb_fetch_ctrl;

    localparam int N      = 64;
    localparam int ISIZE  = 32;
    localparam int ADDR_W = 6;

    logic clk = 1'b0;
    logic reset;
    int   checks   = 0;
    int   failures = 0;

    logic [ISIZE-1:0] rom [64];

    fetch_ctrl_if #(.N(N), .ISIZE(ISIZE), .ADDR_W(ADDR_W)) bus ();

    fetch_ctrl #(
        .N        (N),
        .ISIZE    (ISIZE),
        .ADDR_W   (ADDR_W),
        .DEPTH    (2),
        .RESET_PC (64'h0)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    assign bus.imem_q = rom[bus.imem_addr];

    // Test program. Words 0..13 follow the f8000000/f8008001 pattern. The
    // tail is fixed, and 0x4C is the end marker. Everything past that is
    // nonzero filler.
    function automatic logic [31:0] prog_word(input int i);
        case (i)
            14:      return 32'hcb0e01ce;
            15:      return 32'hb400004e;
            16:      return 32'hcb01000f;
            17:      return 32'h8b01000f;
            18:      return 32'hf803800f;
            19:      return 32'h00000000;
            default: begin
                if (i <= 13) return 32'hf8000000 | (32'(i) << 15) | 32'(i);
                else         return 32'hd5000000 | 32'(i);
            end
        endcase
    endfunction

    initial begin
        for (int i = 0; i < 64; i++) rom[i] = prog_word(i);
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic idle_inputs();
        bus.start       = 1'b0;
        bus.redir_valid = 1'b0;
        bus.redir_pc    = '0;
        bus.out_ready   = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        idle_inputs();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset();
        reset = 1'b1;
        idle_inputs();
        @(negedge clk);
        checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid); end
        checks++; if (bus.out_instr !== 32'h0) begin failures++; $display("FAIL reset_out_instr got=%h exp=0", bus.out_instr); end
        checks++; if (bus.out_pc !== 64'h0) begin failures++; $display("FAIL reset_out_pc got=%h exp=0", bus.out_pc); end
        checks++; if (bus.halted !== 1'b0) begin failures++; $display("FAIL reset_halted got=%b exp=0", bus.halted); end
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
        checks++; if (bus.imem_addr !== 6'd0) begin failures++; $display("FAIL reset_imem_addr got=%0d exp=0", bus.imem_addr); end
        reset = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL idle_no_start_busy got=%b exp=0", bus.busy); end
        checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL idle_no_start_valid got=%b exp=0", bus.out_valid); end
    endtask

    // ------------------------------------------------------------------
    task automatic test_stream();
        do_reset();
        bus.out_ready = 1'b1;
        pulse_start();
        checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL stream_latency_valid got=%b exp=0", bus.out_valid); end
        checks++; if (bus.busy !== 1'b1) begin failures++; $display("FAIL stream_busy got=%b exp=1", bus.busy); end
        @(negedge clk);
        for (int j = 0; j < 19; j++) begin
            checks++; if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL stream_valid[%0d] got=%b exp=1", j, bus.out_valid); end
            checks++; if (bus.out_pc !== 64'(4 * j)) begin failures++; $display("FAIL stream_pc[%0d] got=%h exp=%h", j, bus.out_pc, 64'(4 * j)); end
            checks++; if (bus.out_instr !== prog_word(j)) begin failures++; $display("FAIL stream_instr[%0d] got=%h exp=%h", j, bus.out_instr, prog_word(j)); end
            @(negedge clk);
        end
        checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL stream_end_valid got=%b exp=0", bus.out_valid); end
        checks++; if (bus.halted !== 1'b1) begin failures++; $display("FAIL stream_end_halted got=%b exp=1", bus.halted); end
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL stream_end_busy got=%b exp=0", bus.busy); end
        checks++; if (bus.imem_addr !== 6'd19) begin failures++; $display("FAIL stream_end_addr got=%0d exp=19", bus.imem_addr); end
    endtask

    // ------------------------------------------------------------------
    task automatic test_stall();
        do_reset();
        bus.out_ready = 1'b0;
        pulse_start();
        repeat (4) @(negedge clk);
        checks++; if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL stall_valid got=%b exp=1", bus.out_valid); end
        checks++; if (bus.out_pc !== 64'h0) begin failures++; $display("FAIL stall_pc got=%h exp=0", bus.out_pc); end
        checks++; if (bus.out_instr !== 32'hf8000000) begin failures++; $display("FAIL stall_instr got=%h exp=f8000000", bus.out_instr); end
        checks++; if (bus.imem_addr !== 6'd2) begin failures++; $display("FAIL stall_addr got=%0d exp=2", bus.imem_addr); end
        @(negedge clk);
        checks++; if (bus.out_pc !== 64'h0) begin failures++; $display("FAIL stall_hold_pc got=%h exp=0", bus.out_pc); end
        bus.out_ready = 1'b1;
        for (int j = 0; j < 3; j++) begin
            checks++; if (bus.out_pc !== 64'(4 * j)) begin failures++; $display("FAIL stall_release_pc[%0d] got=%h exp=%h", j, bus.out_pc, 64'(4 * j)); end
            checks++; if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL stall_release_valid[%0d] got=%b exp=1", j, bus.out_valid); end
            @(negedge clk);
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_redirect();
        do_reset();
        bus.out_ready = 1'b0;
        pulse_start();
        repeat (3) @(negedge clk);
        checks++; if (bus.out_pc !== 64'h0) begin failures++; $display("FAIL redir_pre_pc got=%h exp=0", bus.out_pc); end
        bus.redir_valid = 1'b1;
        bus.redir_pc    = 64'h3B;
        bus.out_ready   = 1'b1;
        @(negedge clk);
        bus.redir_valid = 1'b0;
        checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL redir_flush_valid got=%b exp=0", bus.out_valid); end
        checks++; if (bus.imem_addr !== 6'd14) begin failures++; $display("FAIL redir_addr got=%0d exp=14", bus.imem_addr); end
        checks++; if (bus.busy !== 1'b1) begin failures++; $display("FAIL redir_busy got=%b exp=1", bus.busy); end
        @(negedge clk);
        checks++; if (bus.out_pc !== 64'h38) begin failures++; $display("FAIL redir_head0_pc got=%h exp=38", bus.out_pc); end
        checks++; if (bus.out_instr !== 32'hcb0e01ce) begin failures++; $display("FAIL redir_head0_instr got=%h exp=cb0e01ce", bus.out_instr); end
        @(negedge clk);
        checks++; if (bus.out_pc !== 64'h3C) begin failures++; $display("FAIL redir_head1_pc got=%h exp=3c", bus.out_pc); end
        checks++; if (bus.out_instr !== 32'hb400004e) begin failures++; $display("FAIL redir_head1_instr got=%h exp=b400004e", bus.out_instr); end
    endtask

    // ------------------------------------------------------------------
    task automatic test_halt_drain();
        do_reset();
        bus.out_ready   = 1'b0;
        bus.redir_valid = 1'b1;
        bus.redir_pc    = 64'h47;
        bus.start       = 1'b1;
        @(negedge clk);
        bus.redir_valid = 1'b0;
        bus.start       = 1'b0;
        checks++; if (bus.busy !== 1'b1) begin failures++; $display("FAIL halt_redir_start_busy got=%b exp=1", bus.busy); end
        checks++; if (bus.imem_addr !== 6'd17) begin failures++; $display("FAIL halt_redir_start_addr got=%0d exp=17", bus.imem_addr); end
        repeat (2) @(negedge clk);
        checks++; if (bus.out_pc !== 64'h44) begin failures++; $display("FAIL halt_full_pc got=%h exp=44", bus.out_pc); end
        checks++; if (bus.halted !== 1'b0) begin failures++; $display("FAIL halt_full_halted got=%b exp=0", bus.halted); end
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        checks++; if (bus.halted !== 1'b1) begin failures++; $display("FAIL halt_halted got=%b exp=1", bus.halted); end
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL halt_busy got=%b exp=0", bus.busy); end
        checks++; if (bus.imem_addr !== 6'd19) begin failures++; $display("FAIL halt_addr got=%0d exp=19", bus.imem_addr); end
        checks++; if (bus.out_pc !== 64'h48) begin failures++; $display("FAIL halt_drain_pc got=%h exp=48", bus.out_pc); end
        checks++; if (bus.out_instr !== 32'hf803800f) begin failures++; $display("FAIL halt_drain_instr got=%h exp=f803800f", bus.out_instr); end
        @(negedge clk);
        checks++; if (bus.out_pc !== 64'h48) begin failures++; $display("FAIL halt_hold_pc got=%h exp=48", bus.out_pc); end
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL halt_drained_valid got=%b exp=0", bus.out_valid); end
        pulse_start();
        checks++; if (bus.halted !== 1'b1) begin failures++; $display("FAIL halt_start_ignored got=%b exp=1", bus.halted); end
        bus.redir_valid = 1'b1;
        bus.redir_pc    = 64'h40;
        @(negedge clk);
        bus.redir_valid = 1'b0;
        checks++; if (bus.busy !== 1'b1) begin failures++; $display("FAIL halt_resume_busy got=%b exp=1", bus.busy); end
        checks++; if (bus.halted !== 1'b0) begin failures++; $display("FAIL halt_resume_halted got=%b exp=0", bus.halted); end
        @(negedge clk);
        checks++; if (bus.out_pc !== 64'h40) begin failures++; $display("FAIL halt_resume_pc got=%h exp=40", bus.out_pc); end
        checks++; if (bus.out_instr !== 32'hcb01000f) begin failures++; $display("FAIL halt_resume_instr got=%h exp=cb01000f", bus.out_instr); end
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset_midop();
        checks++; if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL midrst_pre_valid got=%b exp=1", bus.out_valid); end
        reset = 1'b1;
        #1;
        checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL midrst_valid got=%b exp=0", bus.out_valid); end
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL midrst_busy got=%b exp=0", bus.busy); end
        checks++; if (bus.imem_addr !== 6'd0) begin failures++; $display("FAIL midrst_addr got=%0d exp=0", bus.imem_addr); end
        @(negedge clk);
        reset = 1'b0;
        idle_inputs();
        bus.out_ready = 1'b1;
        @(negedge clk);
        pulse_start();
        @(negedge clk);
        checks++; if (bus.out_pc !== 64'h0) begin failures++; $display("FAIL midrst_restart_pc got=%h exp=0", bus.out_pc); end
        checks++; if (bus.out_instr !== 32'hf8000000) begin failures++; $display("FAIL midrst_restart_instr got=%h exp=f8000000", bus.out_instr); end
    endtask

    // ------------------------------------------------------------------
    task automatic test_idle_redirect();
        do_reset();
        bus.redir_valid = 1'b1;
        bus.redir_pc    = 64'h0B;
        @(negedge clk);
        bus.redir_valid = 1'b0;
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL idle_redir_busy got=%b exp=0", bus.busy); end
        checks++; if (bus.imem_addr !== 6'd2) begin failures++; $display("FAIL idle_redir_addr got=%0d exp=2", bus.imem_addr); end
        @(negedge clk);
        checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL idle_redir_valid got=%b exp=0", bus.out_valid); end
        bus.out_ready = 1'b1;
        pulse_start();
        @(negedge clk);
        checks++; if (bus.out_pc !== 64'h8) begin failures++; $display("FAIL idle_redir_pc got=%h exp=8", bus.out_pc); end
        checks++; if (bus.out_instr !== 32'hf8010002) begin failures++; $display("FAIL idle_redir_instr got=%h exp=f8010002", bus.out_instr); end
    endtask

    // ------------------------------------------------------------------
    task automatic test_back_to_back();
        do_reset();
        bus.out_ready = 1'b0;
        pulse_start();
        repeat (2) @(negedge clk);
        bus.out_ready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            bus.start = (c == 4);
            checks++; if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL b2b_valid[%0d] got=%b exp=1", c, bus.out_valid); end
            checks++; if (bus.out_pc !== 64'(4 * c)) begin failures++; $display("FAIL b2b_pc[%0d] got=%h exp=%h", c, bus.out_pc, 64'(4 * c)); end
            checks++; if (bus.imem_addr !== 6'(c + 2)) begin failures++; $display("FAIL b2b_addr[%0d] got=%0d exp=%0d", c, bus.imem_addr, c + 2); end
            @(negedge clk);
        end
        bus.start = 1'b0;
    endtask

    // ------------------------------------------------------------------
    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_redirect();
        test_halt_drain();
        test_reset_midop();
        test_idle_redirect();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
